// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// rippling the carry through a register between chunks. start/done handshake,
// reports carry-out and two's-complement signed overflow.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST  = N - 1;
    localparam int unsigned SUM_W = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               c_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   psum_q;
    logic [WIDTH-1:0]   s_q;
    logic               carry_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [SUM_W-1:0]   chunk_sum_c;
    logic [WIDTH-1:0]   psum_next_c;

    // Add the low chunk of both operands plus the rippled carry; shift the chunk into the top of the partial sum.
    always_comb begin
        chunk_sum_c = SUM_W'(a_q[CHUNK-1:0]) + SUM_W'(b_q[CHUNK-1:0]) + SUM_W'(c_q);
        psum_next_c = WIDTH'({chunk_sum_c[CHUNK-1:0], psum_q} >> CHUNK);
    end

    // Control FSM and datapath registers; result outputs update only on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            psum_q   <= '0;
            s_q      <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert B and force the carry-in.
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        c_q      <= sub ? 1'b1 : cin;
                        sign_a_q <= a[WIDTH-1];
                        sign_b_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        cnt_q    <= '0;
                        psum_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    c_q    <= chunk_sum_c[CHUNK];
                    psum_q <= psum_next_c;
                    a_q    <= a_q >> CHUNK;
                    b_q    <= b_q >> CHUNK;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST)) begin
                        s_q     <= psum_next_c;
                        carry_q <= chunk_sum_c[CHUNK];
                        ovf_q   <= (sign_a_q == sign_b_q) && (psum_next_c[WIDTH-1] != sign_a_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign s        = s_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three configurations (8/2, 16/4, 8/8) share one stimulus
// stream; an arithmetic reference model predicts every output on every cycle.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic        busy0, done0, carry0, ovf0;
    logic [7:0]  s0;
    logic        busy1, done1, carry1, ovf1;
    logic [15:0] s1;
    logic        busy2, done2, carry2, ovf2;
    logic [7:0]  s2;

    logic        got_busy [3];
    logic        got_done [3];
    logic        got_c    [3];
    logic        got_v    [3];
    logic [15:0] got_s    [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy0), .done(done0), .s(s0), .carry(carry0), .overflow(ovf0));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .s(s1), .carry(carry1), .overflow(ovf1));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy2), .done(done2), .s(s2), .carry(carry2), .overflow(ovf2));

    always_comb begin
        got_busy[0] = busy0; got_done[0] = done0; got_c[0] = carry0; got_v[0] = ovf0; got_s[0] = 16'(s0);
        got_busy[1] = busy1; got_done[1] = done1; got_c[1] = carry1; got_v[1] = ovf1; got_s[1] = s1;
        got_busy[2] = busy2; got_done[2] = done2; got_c[2] = carry2; got_v[2] = ovf2; got_s[2] = 16'(s2);
    end

    function automatic int wof(input int i);
        return (i == 1) ? 16 : 8;
    endfunction

    function automatic int cof(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 8);
    endfunction

    // Plain-arithmetic result: {overflow, carry, sum}
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                           input logic sb, input logic ci);
        longint unsigned mask, aa, bb, tot;
        logic [15:0] r;
        logic c, v, sa, sbb, sr;
        mask = (64'd1 << w) - 64'd1;
        aa   = 64'(av) & mask;
        bb   = (sb ? ~64'(bv) : 64'(bv)) & mask;
        tot  = aa + bb + (sb ? 64'd1 : 64'(ci));
        r    = 16'(tot & mask);
        c    = ((tot >> w) & 64'd1) != 64'd0;
        sa   = ((aa >> (w - 1)) & 64'd1) != 64'd0;
        sbb  = ((bb >> (w - 1)) & 64'd1) != 64'd0;
        sr   = ((64'(r) >> (w - 1)) & 64'd1) != 64'd0;
        v    = (sa == sbb) && (sr != sa);
        return {v, c, r};
    endfunction

    // Reference model: cycles remaining for the op in flight, then publish its result.
    int          m_left [3] = '{0, 0, 0};
    logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_s    [3] = '{16'd0, 16'd0, 16'd0};
    logic        m_c    [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_v    [3] = '{1'b0, 1'b0, 1'b0};
    logic [17:0] p_r    [3] = '{18'd0, 18'd0, 18'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_left[i] <= 0;
                m_done[i] <= 1'b0;
                m_s[i]    <= 16'd0;
                m_c[i]    <= 1'b0;
                m_v[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_s[i]    <= p_r[i][15:0];
                        m_c[i]    <= p_r[i][16];
                        m_v[i]    <= p_r[i][17];
                        m_done[i] <= 1'b1;
                    end else begin
                        m_done[i] <= 1'b0;
                    end
                end else begin
                    m_done[i] <= 1'b0;
                    if (start) begin
                        p_r[i]    <= ref_op(wof(i), a, b, sub, cin);
                        m_left[i] <= wof(i) / cof(i);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h exp=%0h at %0t", nm, i, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("busy",     i, 16'(got_busy[i]), 16'(m_left[i] != 0));
            chk("done",     i, 16'(got_done[i]), 16'(m_done[i]));
            chk("s",        i, got_s[i],         m_s[i]);
            chk("carry",    i, 16'(got_c[i]),    16'(m_c[i]));
            chk("overflow", i, 16'(got_v[i]),    16'(m_v[i]));
        end
    end

    // Returns at posedge+1 with every instance out of RUN.
    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((got_busy[0] || got_busy[1] || got_busy[2]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got=busy exp=idle at %0t", $time);
        end
    endtask

    // One operation with literal expectations for instance i.
    task automatic run_lit(input int i, input logic sb, input logic [15:0] av, input logic [15:0] bv,
                           input logic ci, input logic [15:0] es, input logic ec, input logic ev,
                           input int elat, input logic glitch);
        int lat;
        wait_idle();
        start = 1'b1; sub = sb; a = av; b = bv; cin = ci;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            if (glitch && lat == 1) begin
                start = 1'b1; a = 16'h6363; b = 16'h6363; sub = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); lat++; #1;
            if (got_done[i]) break;
        end
        start = 1'b0;
        chk("latency",   i, 16'(lat), 16'(elat));
        chk("lit_s",     i, got_s[i], es);
        chk("lit_carry", i, 16'(got_c[i]), 16'(ec));
        chk("lit_ovf",   i, 16'(got_v[i]), 16'(ev));
    endtask

    initial begin
        int prev, ndone;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 0, 16'(got_busy[0]), 16'd0);
        chk("rst_done", 0, 16'(got_done[0]), 16'd0);
        chk("rst_s",    1, got_s[1], 16'd0);
        rst_n = 1'b1;

        // Directed cases with hand-computed results
        run_lit(0, 1'b0, 16'd29,  16'd5,   1'b0, 16'd34,  1'b0, 1'b0, 4, 1'b0);
        @(posedge clk); #1;
        chk("hold_s",    0, got_s[0], 16'd34);
        chk("hold_done", 0, 16'(got_done[0]), 16'd0);
        run_lit(0, 1'b0, 16'd78,  16'd255, 1'b0, 16'd77,  1'b1, 1'b0, 4, 1'b0);
        run_lit(0, 1'b0, 16'd100, 16'd100, 1'b0, 16'd200, 1'b0, 1'b1, 4, 1'b0);
        run_lit(0, 1'b0, 16'd200, 16'd95,  1'b0, 16'd39,  1'b1, 1'b0, 4, 1'b0);
        run_lit(0, 1'b1, 16'd43,  16'd59,  1'b1, 16'd240, 1'b0, 1'b0, 4, 1'b0);
        run_lit(0, 1'b1, 16'd59,  16'd43,  1'b0, 16'd16,  1'b1, 1'b0, 4, 1'b0);
        run_lit(1, 1'b0, 16'hFFFF, 16'd0,  1'b1, 16'd0,   1'b1, 1'b0, 4, 1'b0);
        run_lit(2, 1'b0, 16'd191, 16'd2,   1'b0, 16'd193, 1'b0, 1'b0, 1, 1'b0);

        // start re-pulsed mid-RUN must not disturb the operation in flight
        run_lit(0, 1'b0, 16'd10,  16'd20,  1'b0, 16'd30,  1'b0, 1'b0, 4, 1'b1);

        // start held high: a completion every N+1 cycles
        wait_idle();
        prev = -1; ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            start = 1'b1; sub = 1'($urandom); cin = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            if (got_done[0]) begin
                if (prev >= 0) chk("period", 0, 16'(cyc - prev), 16'd5);
                prev = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        chk("ndone", 0, 16'(ndone), 16'd8);

        // Reset in the middle of RUN
        run_lit(0, 1'b0, 16'd78, 16'd255, 1'b0, 16'd77, 1'b1, 1'b0, 4, 1'b0);
        wait_idle();
        start = 1'b1; sub = 1'b0; a = 16'd29; b = 16'd5; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  0, 16'(got_busy[0]), 16'd0);
        chk("arst_done",  0, 16'(got_done[0]), 16'd0);
        chk("arst_s",     0, got_s[0], 16'd0);
        chk("arst_carry", 0, 16'(got_c[0]), 16'd0);
        chk("arst_ovf",   0, 16'(got_v[0]), 16'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_lit(0, 1'b0, 16'd29, 16'd5, 1'b0, 16'd34, 1'b0, 1'b0, 4, 1'b0);

        // Randomized traffic, checked every cycle by the compare process
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) != 0);
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
